neopixel_frame_ctrl: RTL and testbench

Frame-level controller for the NeoPixel serial driver. It holds a double-buffered GRB pixel frame written by the host and hands it to the driver as a stable parallel word. It sequences the driver's start/busy handshake and enforces the latch gap between frames. It also re-sends the frame periodically or on host commit, and flags a driver that never starts.

---
 rtl/neopixel_pkg.sv | 26 ++
 rtl/neopixel_gap_timer.sv | 27 ++
 rtl/neopixel_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_neopixel_frame_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopixel_pkg.sv
// Shared types and default timing for the NeoPixel frame controller.
package neopixel_pkg;

  localparam int unsigned PIXEL_W            = 24;
  localparam int unsigned DEF_NBR_PIXELS     = 8;
  localparam int unsigned DEF_AW             = 3;
  localparam int unsigned DEF_LATCH_CYCLES   = 1280;
  localparam int unsigned DEF_REFRESH_CYCLES = 0;
  localparam int unsigned DEF_START_TIMEOUT  = 16;

  typedef enum logic [1:0] {IDLE, START, SEND, LATCH} np_state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/neopixel_gap_timer.sv
// Loadable saturating down-counter; done is registered and high while the count is zero.
module neopixel_gap_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk_16MHz,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= load_val;
      done <= (load_val == '0);
    end else if (cnt != '0) begin
      cnt  <= cnt - CW'(1);
      done <= (cnt == CW'(1));
    end
  end

endmodule

// File: rtl/neopixel_frame_ctrl.sv
// Double-buffered GRB frame store plus start/busy/latch sequencing for the NeoPixel driver.
module neopixel_frame_ctrl
  import neopixel_pkg::*;
#(
  parameter int unsigned nbr_pixels     = DEF_NBR_PIXELS,
  parameter int unsigned AW             = DEF_AW,
  parameter int unsigned LATCH_CYCLES   = DEF_LATCH_CYCLES,
  parameter int unsigned REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int unsigned START_TIMEOUT  = DEF_START_TIMEOUT
) (
  input  logic                          clk_16MHz,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [AW-1:0]                 wr_addr,
  input  logic [PIXEL_W-1:0]            wr_data,
  input  logic                          commit,
  output logic [nbr_pixels*PIXEL_W-1:0] pix_data,
  output logic                          pix_start,
  input  logic                          pix_busy,
  output logic                          sending,
  output logic                          frame_done,
  output logic                          err_timeout
);

  localparam int unsigned FRAME_W = nbr_pixels * PIXEL_W;
  localparam int unsigned TMAX    = max3(LATCH_CYCLES, START_TIMEOUT, REFRESH_CYCLES);
  localparam int unsigned CW      = $clog2(TMAX + 1);
  localparam bit          REFRESH_EN = (REFRESH_CYCLES != 0);

  localparam logic [CW-1:0] START_LOAD =
    CW'((START_TIMEOUT > 1) ? START_TIMEOUT - 1 : 32'd0);
  localparam logic [CW-1:0] LATCH_LOAD =
    CW'((LATCH_CYCLES > 1) ? LATCH_CYCLES - 1 : 32'd0);
  localparam logic [CW-1:0] REFRESH_LOAD =
    CW'((REFRESH_CYCLES > 1) ? REFRESH_CYCLES - 1 : 32'd0);
  // First IDLE cycle after reset spends one count arming the timer.
  localparam logic [CW-1:0] FIRST_LOAD =
    CW'((REFRESH_CYCLES > 2) ? REFRESH_CYCLES - 2 : 32'd0);

  np_state_e          state;
  grb_t               shadow [nbr_pixels];
  logic [FRAME_W-1:0] shadow_flat;
  logic               pending;
  logic               primed;
  logic               wr_hit;
  logic               take_commit;
  logic               take_refresh;
  logic               start_expired;
  logic               tmr_load;
  logic [CW-1:0]      tmr_val;
  logic               tmr_done;

  // Pixel 0 sits in the most significant slice so it is shifted out first.
  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < int'(nbr_pixels); i++)
      shadow_flat[FRAME_W-1-PIXEL_W*i -: PIXEL_W] = shadow[i];
  end

  // Transition decode shared by the FSM and the time-shared gap timer.
  always_comb begin
    wr_hit        = wr_en && (32'(wr_addr) < nbr_pixels);
    take_commit   = (state == IDLE) && pending;
    take_refresh  = (state == IDLE) && !pending && REFRESH_EN &&
                    (primed ? tmr_done : (REFRESH_CYCLES == 1));
    start_expired = (state == START) && !pix_busy && tmr_done;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    if (take_commit || take_refresh) begin
      tmr_load = 1'b1;
      tmr_val  = START_LOAD;
    end else if ((state == IDLE) && !primed) begin
      tmr_load = 1'b1;
      tmr_val  = FIRST_LOAD;
    end else if (start_expired) begin
      tmr_load = 1'b1;
      tmr_val  = REFRESH_LOAD;
    end else if ((state == SEND) && !pix_busy) begin
      tmr_load = 1'b1;
      tmr_val  = LATCH_LOAD;
    end else if ((state == LATCH) && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = REFRESH_LOAD;
    end
  end

  neopixel_gap_timer #(.CW(CW)) u_gap_timer (
    .clk_16MHz (clk_16MHz),
    .rst_n     (rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .done      (tmr_done)
  );

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pending     <= 1'b0;
      primed      <= 1'b0;
      pix_data    <= '0;
      pix_start   <= 1'b0;
      sending     <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      for (int i = 0; i < int'(nbr_pixels); i++) shadow[i] <= '0;
    end else begin
      primed     <= 1'b1;
      frame_done <= 1'b0;
      // A commit on the consuming edge is kept for the following frame.
      pending    <= commit || (pending && !take_commit);
      if (wr_hit) shadow[wr_addr] <= grb_t'(wr_data);
      unique case (state)
        IDLE: begin
          if (take_commit) begin
            pix_data  <= shadow_flat;
            pix_start <= 1'b1;
            sending   <= 1'b1;
            state     <= START;
          end else if (take_refresh) begin
            pix_start <= 1'b1;
            sending   <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (pix_busy) begin
            state <= SEND;
          end else if (start_expired) begin
            err_timeout <= 1'b1;
            pix_start   <= 1'b0;
            sending     <= 1'b0;
            state       <= IDLE;
          end
        end
        SEND: begin
          if (!pix_busy) begin
            pix_start <= 1'b0;
            state     <= LATCH;
          end
        end
        LATCH: begin
          if (tmr_done) begin
            sending    <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_frame_ctrl.sv
// Self-checking bench: cycle-level reference model plus directed scenarios with literal expectations.
module tb_neopixel_frame_ctrl;

  localparam int NP       = 6;
  localparam int AW       = 3;
  localparam int LC       = 1280;
  localparam int RC       = 100;
  localparam int ST       = 16;
  localparam int BUSY_LEN = 30;
  localparam int FW       = NP * 24;

  logic          clk_16MHz = 1'b0;
  logic          rst_n     = 1'b0;
  logic          wr_en     = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [23:0]   wr_data   = '0;
  logic          commit    = 1'b0;
  logic          pix_busy  = 1'b0;
  logic [FW-1:0] pix_data;
  logic          pix_start;
  logic          sending;
  logic          frame_done;
  logic          err_timeout;

  logic drv_en    = 1'b1;
  logic drv_armed = 1'b1;
  int   drv_left  = 0;

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_frames = 0;
  logic prev_start = 1'b0;
  logic chk_en   = 1'b0;

  neopixel_frame_ctrl #(
    .nbr_pixels     (NP),
    .AW             (AW),
    .LATCH_CYCLES   (LC),
    .REFRESH_CYCLES (RC),
    .START_TIMEOUT  (ST)
  ) dut (
    .clk_16MHz   (clk_16MHz),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .commit      (commit),
    .pix_data    (pix_data),
    .pix_start   (pix_start),
    .pix_busy    (pix_busy),
    .sending     (sending),
    .frame_done  (frame_done),
    .err_timeout (err_timeout)
  );

  always #31 clk_16MHz = ~clk_16MHz;

  // Driver stand-in: busy rises half a cycle after it sees start, re-arms once start is low.
  always @(negedge clk_16MHz) begin
    if (pix_busy) begin
      if (drv_left <= 1) pix_busy <= 1'b0;
      drv_left <= drv_left - 1;
    end else if (drv_en && drv_armed && pix_start) begin
      pix_busy  <= 1'b1;
      drv_left  <= BUSY_LEN;
      drv_armed <= 1'b0;
    end
    if (!pix_start) drv_armed <= 1'b1;
  end

  always @(posedge clk_16MHz) begin
    prev_start <= pix_start;
    if (pix_start && !prev_start) n_frames <= n_frames + 1;
  end

  // Reference model: phase plus elapsed-cycle count, buffers as arrays.
  int          m_phase;
  int          m_cnt;
  logic [23:0] m_shadow [NP];
  logic [23:0] m_active [NP];
  logic        m_pending, m_start, m_done, m_err;
  logic [FW-1:0] exp_data;

  always @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= 0;
      m_cnt     <= 0;
      m_pending <= 1'b0;
      m_start   <= 1'b0;
      m_done    <= 1'b0;
      m_err     <= 1'b0;
      for (int i = 0; i < NP; i++) begin
        m_shadow[i] <= '0;
        m_active[i] <= '0;
      end
    end else begin
      m_done <= 1'b0;
      m_cnt  <= m_cnt + 1;
      if (wr_en && int'(wr_addr) < NP) m_shadow[wr_addr] <= wr_data;
      m_pending <= commit || (m_pending && m_phase != 0);
      case (m_phase)
        0: begin
          if (m_pending) begin
            for (int i = 0; i < NP; i++) m_active[i] <= m_shadow[i];
            m_phase <= 1; m_cnt <= 0; m_start <= 1'b1;
          end else if (RC > 0 && m_cnt + 1 == RC) begin
            m_phase <= 1; m_cnt <= 0; m_start <= 1'b1;
          end
        end
        1: begin
          if (pix_busy) begin
            m_phase <= 2; m_cnt <= 0;
          end else if (m_cnt + 1 == ST) begin
            m_err <= 1'b1; m_start <= 1'b0; m_phase <= 0; m_cnt <= 0;
          end
        end
        2: begin
          if (!pix_busy) begin
            m_start <= 1'b0; m_phase <= 3; m_cnt <= 0;
          end
        end
        default: begin
          if (m_cnt + 1 == LC) begin
            m_done <= 1'b1; m_phase <= 0; m_cnt <= 0;
          end
        end
      endcase
    end
  end

  always_comb begin
    exp_data = '0;
    for (int i = 0; i < NP; i++) exp_data[FW-1-24*i -: 24] = m_active[i];
  end

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_16MHz) begin
    if (chk_en) begin
      check("pix_data",    pix_data, exp_data);
      check("pix_start",   FW'(pix_start),   FW'(m_start));
      check("sending",     FW'(sending),     FW'(m_phase != 0));
      check("frame_done",  FW'(frame_done),  FW'(m_done));
      check("err_timeout", FW'(err_timeout), FW'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk_16MHz);
    #1;
  endtask

  function automatic logic sig_of(input int which);
    case (which)
      0:       return pix_start;
      1:       return frame_done;
      2:       return pix_busy;
      default: return err_timeout;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input int budget, output int n);
    n = 0;
    while (sig_of(which) !== val && n < budget) begin
      tick();
      n++;
    end
    if (sig_of(which) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_sig%0d: still %b after %0d cycles, wanted %b", which, sig_of(which),
               budget, val);
    end
  endtask

  task automatic px_write(input logic [AW-1:0] a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  function automatic logic [23:0] px(input int i);
    return pix_data[FW-1-24*i -: 24];
  endfunction

  initial begin
    int n;
    int f0;
    logic [FW-1:0] exp_frame;

    tick(); tick();
    chk_en = 1'b1;
    check("rst_pix_data",   pix_data, '0);
    check("rst_pix_start",  FW'(pix_start),   '0);
    check("rst_sending",    FW'(sending),     '0);
    check("rst_frame_done", FW'(frame_done),  '0);
    check("rst_err",        FW'(err_timeout), '0);
    rst_n = 1'b1;

    // Basic frame; pixel 1 written on the commit edge must be included.
    px_write(3'd0, 24'hFF0000);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h00FF00; commit = 1'b1;
    tick();
    wr_en = 1'b0; commit = 1'b0;
    check("start_not_yet",  FW'(pix_start), '0);
    check("px0_not_copied", FW'(px(0)), '0);
    tick();
    check("start_after_commit", FW'(pix_start), FW'(1'b1));
    check("basic_px0", FW'(px(0)), FW'(24'hFF0000));
    check("basic_px1", FW'(px(1)), FW'(24'h00FF00));
    wait_sig(0, 1'b0, 300, n);
    wait_sig(1, 1'b1, 3000, n);
    check("latch_len", FW'(n), FW'(LC));
    tick();
    check("frame_done_one_cycle", FW'(frame_done), '0);

    // Commit during SEND: current frame keeps old data, next frame follows frame_done by one cycle.
    do_commit();
    tick();
    check("frame2_start", FW'(pix_start), FW'(1'b1));
    wait_sig(2, 1'b1, 20, n);
    tick(); tick(); tick();
    px_write(3'd0, 24'h0000FF);
    do_commit();
    check("send_px0_held", FW'(px(0)), FW'(24'hFF0000));
    wait_sig(1, 1'b1, 3000, n);
    check("done_px0_held", FW'(px(0)), FW'(24'hFF0000));
    tick();
    check("frame3_start_next_cycle", FW'(pix_start), FW'(1'b1));
    check("frame3_px0", FW'(px(0)), FW'(24'h0000FF));
    check("frame3_px1", FW'(px(1)), FW'(24'h00FF00));

    // Three commits during LATCH merge into one frame.
    wait_sig(0, 1'b0, 300, n);
    f0 = n_frames;
    px_write(3'd2, 24'h123456);
    do_commit();
    repeat (5) tick();
    do_commit();
    repeat (5) tick();
    do_commit();
    wait_sig(1, 1'b1, 3000, n);
    tick();
    check("merged_start", FW'(pix_start), FW'(1'b1));
    check("merged_px2", FW'(px(2)), FW'(24'h123456));
    wait_sig(0, 1'b0, 300, n);
    wait_sig(1, 1'b1, 3000, n);
    check("merged_frame_count", FW'(n_frames - f0), FW'(1));

    // Auto-refresh after 100 IDLE cycles, re-sending the active frame; bad addresses ignored.
    wait_sig(0, 1'b1, 300, n);
    check("refresh_gap", FW'(n), FW'(RC));
    check("refresh_px2", FW'(px(2)), FW'(24'h123456));
    px_write(3'd6, 24'hABCDEF);
    px_write(3'd7, 24'h654321);
    wait_sig(0, 1'b0, 300, n);
    wait_sig(1, 1'b1, 3000, n);
    do_commit();
    tick();
    exp_frame = {24'h0000FF, 24'h00FF00, 24'h123456, 72'h0};
    check("bad_addr_frame", pix_data, exp_frame);
    wait_sig(0, 1'b0, 300, n);
    wait_sig(1, 1'b1, 3000, n);

    // Start timeout with the driver silent; error is sticky.
    drv_en = 1'b0;
    do_commit();
    tick();
    check("to_start", FW'(pix_start), FW'(1'b1));
    wait_sig(0, 1'b0, 100, n);
    check("to_cycles", FW'(n), FW'(ST));
    check("to_err", FW'(err_timeout), FW'(1'b1));
    check("to_idle", FW'(sending), '0);
    repeat (150) tick();
    check("to_err_sticky", FW'(err_timeout), FW'(1'b1));

    // Asynchronous reset in the middle of SEND.
    drv_en = 1'b1;
    do_commit();
    tick();
    wait_sig(2, 1'b1, 40, n);
    tick(); tick(); tick();
    check("pre_reset_sending", FW'(sending), FW'(1'b1));
    #10 rst_n = 1'b0;
    #1;
    check("arst_pix_data",   pix_data, '0);
    check("arst_pix_start",  FW'(pix_start),   '0);
    check("arst_sending",    FW'(sending),     '0);
    check("arst_frame_done", FW'(frame_done),  '0);
    check("arst_err",        FW'(err_timeout), '0);
    tick(); tick();
    rst_n = 1'b1;
    wait_sig(2, 1'b0, 100, n);
    px_write(3'd0, 24'h00AA00);
    do_commit();
    tick();
    check("post_reset_start", FW'(pix_start), FW'(1'b1));
    exp_frame = {24'h00AA00, 120'h0};
    check("post_reset_frame", pix_data, exp_frame);
    wait_sig(0, 1'b0, 300, n);
    wait_sig(1, 1'b1, 3000, n);
    check("post_reset_latch", FW'(n), FW'(LC));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
